// File: rtl/axis_bram_capture_ctrl.sv
// Pre/post-trigger capture sequencer writing an AXI4-Stream into a circular single-port BRAM.
// Optional macro CAPTURE_TRIG_EDGE_EN selects a rising-edge trigger instead of a level trigger.
module axis_bram_capture_ctrl #(
   parameter int unsigned AXIS_TDATA_WIDTH = 32,
   parameter int unsigned BRAM_DATA_WIDTH  = 32,
   parameter int unsigned BRAM_ADDR_WIDTH  = 10
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_pre,
   input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_post,
   input  logic                        ctl_arm,
   input  logic                        trg_flag,
   output logic [BRAM_ADDR_WIDTH-1:0]  sts_addr,
   output logic [2:0]                  sts_state,
   output logic                        sts_done,
   output logic                        s_axis_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic                        bram_porta_clk,
   output logic                        bram_porta_rst,
   output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
   output logic [BRAM_DATA_WIDTH-1:0]  bram_porta_wrdata,
   output logic                        bram_porta_we
);

   localparam int unsigned AW = BRAM_ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_WAIT = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t        state, state_n;
   logic [AW-1:0] ptr, ptr_n;
   logic [AW-1:0] pre_cnt, pre_cnt_n;
   logic [AW-1:0] post_cnt, post_cnt_n;
   logic [AW-1:0] pre_cfg, pre_cfg_n;
   logic [AW-1:0] post_cfg, post_cfg_n;
   logic [AW-1:0] trig_addr, trig_addr_n;
   logic          done_q, done_n;
   logic          beat;
   logic          capturing;
   logic          trig_hit;
   logic [AW-1:0] pre_inc;
   logic [AW-1:0] post_inc;

   // Upstream is never stalled; beats outside a capture are simply dropped.
   assign s_axis_tready  = 1'b1;
   assign beat           = s_axis_tvalid & s_axis_tready;
   assign capturing      = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
   assign bram_porta_we  = beat & capturing;
   assign bram_porta_clk = aclk;
   assign bram_porta_rst = ~aresetn;
   assign bram_porta_addr = ptr;
   assign sts_addr       = trig_addr;
   assign sts_state      = 3'(state);
   assign sts_done       = done_q;
   assign pre_inc        = pre_cnt + AW'(1);
   assign post_inc       = post_cnt + AW'(1);

   generate
      if (BRAM_DATA_WIDTH <= AXIS_TDATA_WIDTH) begin : g_trunc
         assign bram_porta_wrdata = s_axis_tdata[BRAM_DATA_WIDTH-1:0];
      end else begin : g_zext
         assign bram_porta_wrdata = {{(BRAM_DATA_WIDTH-AXIS_TDATA_WIDTH){1'b0}}, s_axis_tdata};
      end
   endgenerate

`ifdef CAPTURE_TRIG_EDGE_EN
   logic prev_flag, prev_flag_n;

   // Flag value seen on the previous accepted beat; cleared on arm so a held flag cannot fire.
   assign prev_flag_n = ctl_arm ? 1'b0 : (beat ? trg_flag : prev_flag);
   assign trig_hit    = trg_flag & ~prev_flag;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) prev_flag <= 1'b0;
      else          prev_flag <= prev_flag_n;
   end
`else
   assign trig_hit = trg_flag;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= S_IDLE;
         ptr       <= '0;
         pre_cnt   <= '0;
         post_cnt  <= '0;
         pre_cfg   <= '0;
         post_cfg  <= '0;
         trig_addr <= '0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         pre_cnt   <= pre_cnt_n;
         post_cnt  <= post_cnt_n;
         pre_cfg   <= pre_cfg_n;
         post_cfg  <= post_cfg_n;
         trig_addr <= trig_addr_n;
         done_q    <= done_n;
      end
   end

   // Next-state logic; arm overrides every other transition.
   always_comb begin
      state_n     = state;
      ptr_n       = bram_porta_we ? ptr + AW'(1) : ptr;
      pre_cnt_n   = pre_cnt;
      post_cnt_n  = post_cnt;
      pre_cfg_n   = pre_cfg;
      post_cfg_n  = post_cfg;
      trig_addr_n = trig_addr;

      case (state)
         S_PRE: begin
            if (pre_cfg == '0) begin
               state_n = S_WAIT;
            end else if (beat) begin
               pre_cnt_n = pre_inc;
               if (pre_inc == pre_cfg) state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (beat && trig_hit) begin
               trig_addr_n = ptr;
               state_n     = (post_cfg == '0) ? S_DONE : S_POST;
            end
         end
         S_POST: begin
            if (beat) begin
               post_cnt_n = post_inc;
               if (post_inc == post_cfg) state_n = S_DONE;
            end
         end
         default: ;
      endcase

      if (ctl_arm) begin
         state_n     = S_PRE;
         ptr_n       = '0;
         pre_cnt_n   = '0;
         post_cnt_n  = '0;
         pre_cfg_n   = cfg_pre;
         post_cfg_n  = cfg_post;
         trig_addr_n = trig_addr;
      end

      done_n = (state_n == S_DONE);
   end

endmodule

// File: doc/axis_bram_capture_ctrl.md
Name: axis_bram_capture_ctrl

Overview:
Sequences pre/post-trigger sample capture from an AXI4-Stream source into a single-port BRAM. The BRAM is used as a circular buffer. The block arms on command, guarantees a minimum pre-trigger fill, waits for a trigger beat, writes a programmed number of post-trigger samples, then stops and reports the trigger address. It sits between an ADC/DSP stream and the BRAM port that the PS reads back.

Parameters:
AXIS_TDATA_WIDTH, 32, width of s_axis_tdata
BRAM_DATA_WIDTH, 32, BRAM word width; wrdata is tdata truncated or zero-extended to this width
BRAM_ADDR_WIDTH, 10, BRAM address width; buffer depth D = 2^BRAM_ADDR_WIDTH

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cfg_pre  in  BRAM_ADDR_WIDTH  minimum pre-trigger samples
cfg_post  in  BRAM_ADDR_WIDTH  post-trigger samples written after the trigger sample
ctl_arm  in  1  single-cycle arm/restart strobe
trg_flag  in  1  trigger input, sampled only on accepted beats
sts_addr  out  BRAM_ADDR_WIDTH  BRAM address of the trigger sample
sts_state  out  3  one-hot-free encoding: 0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE
sts_done  out  1  high while in DONE
s_axis_tready  out  1  stream ready
s_axis_tdata  in  AXIS_TDATA_WIDTH  stream data
s_axis_tvalid  in  1  stream valid
bram_porta_clk  out  1  = aclk
bram_porta_rst  out  1  = ~aresetn
bram_porta_addr  out  BRAM_ADDR_WIDTH  write address (registered pointer)
bram_porta_wrdata  out  BRAM_DATA_WIDTH  = s_axis_tdata
bram_porta_we  out  1  write enable

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; addr pointer, pre counter and post counter = 0; sts_addr = 0; sts_done = 0; we = 0.
- s_axis_tready = 1 in every state after reset, so the upstream never stalls. Beats arriving in IDLE/DONE are accepted and discarded.
- Beat = tvalid & tready. bram_porta_we = beat & state in {PRE, WAIT, POST}. This is combinational; the write lands at the current pointer in the same cycle.
- Pointer increments by 1 on each written beat and wraps D-1 -> 0 naturally (modulo D).
- ctl_arm, in any state: next state PRE; pointer, pre counter and post counter cleared; sts_done drops next cycle; sts_addr holds its old value until the next trigger. ctl_arm wins over any same-cycle transition.
- PRE: counts written beats. When the count reaches min(cfg_pre, D-1) -> WAIT. cfg_pre = 0 -> WAIT on the cycle after arm. Triggers are ignored in PRE.
- WAIT: writes continuously and circularly. A beat with trg_flag = 1 writes the trigger sample and latches sts_addr = pointer. Next state is POST, or DONE if cfg_post = 0. trg_flag without tvalid is ignored.
- POST: writes beats and counts them. The beat that makes the count equal cfg_post is written, then next state is DONE. cfg_post >= D wraps over the pre-trigger data; this is permitted and not flagged.
- DONE: we = 0, pointer frozen, sts_done = 1. The state holds until ctl_arm.
- cfg_pre and cfg_post are sampled at ctl_arm into internal registers. Changes mid-capture have no effect.
- Latency: trigger beat at cycle N -> sts_addr valid at N+1. Last post beat at cycle M -> sts_done = 1 at M+1.
- Readout address of the oldest valid sample is sts_addr - pre_written (mod D). Software computes it; the block does not.

Optional Feature:
CAPTURE_TRIG_EDGE_EN
- Defined: the trigger fires on a beat where trg_flag = 1 and trg_flag was 0 on the previous accepted beat. The previous-value register is cleared on reset and on ctl_arm, so a flag already high at arm does not fire.
- Undefined: level-sensitive, as in Behaviour.

Test Plan:
- Reset mid-POST with tvalid held high -> next edge shows state 0, we = 0, addr 0, sts_done 0.
- D = 1024, cfg_pre = 4, cfg_post = 3, tvalid always, trg_flag high from arm -> trigger taken on beat 5 at addr 4, sts_addr = 4, writes at addr 0..7, sts_done = 1 after beat 8.
- Same config, trigger raised after 1030 beats -> pointer wraps 1023 -> 0, sts_addr = 1030 mod 1024 = 6, post writes at 7, 8, 9.
- cfg_post = 0, trigger on beat at addr 10 -> only addr 10 written after the trigger, DONE the next cycle, no further we.
- ctl_arm pulsed in POST at addr 50 -> next cycle state PRE, addr 0, sts_done 0; tvalid gaps during PRE do not advance the counter.
- CAPTURE_TRIG_EDGE_EN, trg_flag held high across arm -> no trigger until trg_flag goes low then high; sts_addr = address of that rising beat.
